// File: rtl/one_hot_rr_arbiter.sv
// one_hot_rr_arbiter: registered round-robin arbiter issuing a one-hot grant plus binary index
// under a valid/ready handshake, with a one-cycle holdoff after each accept.
module one_hot_rr_arbiter #(
    parameter int DATA_DEPTH  = 8,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_DEPTH-1:0]  req,
    input  logic                   grant_ready,
    output logic [DATA_DEPTH-1:0]  grant,
    output logic                   grant_valid,
    output logic [INDEX_WIDTH-1:0] grant_index
);
    typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] ptr;
    logic [INDEX_WIDTH-1:0] sel;
    logic                   found;

    // Search starts at ptr and wraps explicitly so non-power-of-two depths never see stale bits
    always_comb begin
        sel = '0;
        found = 1'b0;
        for (int i = 0; i < DATA_DEPTH; i++) begin
            int c;
            c = int'(ptr) + i;
            c = (c >= DATA_DEPTH) ? c - DATA_DEPTH : c;
            if (!found && req[c]) begin
                found = 1'b1;
                sel = INDEX_WIDTH'(c);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant       <= DATA_DEPTH'(1) << sel;
                        grant_index <= sel;
                        grant_valid <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_ready) begin
                        ptr         <= (grant_index == INDEX_WIDTH'(DATA_DEPTH - 1)) ? '0 : grant_index + INDEX_WIDTH'(1);
                        grant       <= '0;
                        grant_index <= '0;
                        grant_valid <= 1'b0;
                        state       <= HOLDOFF;
                    end
                end
                HOLDOFF: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_one_hot_rr_arbiter.sv
// tb_one_hot_rr_arbiter: scoreboard bench; a behavioural model predicts each cycle's outputs,
// directed scenarios plus a long random run with invariant and fairness checks.
module tb_one_hot_rr_arbiter;
    localparam int N = 8;
    localparam int W = 3;

    typedef struct packed {
        logic [N-1:0] g;
        logic         v;
        logic [W-1:0] i;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         grant_ready = 1'b0;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [W-1:0] grant_index;

    int n_tests = 0;
    int n_fail  = 0;

    int           m_state = 0;
    int           m_ptr   = 0;
    int           m_idx   = 0;
    logic [N-1:0] m_grant = '0;
    logic         m_valid = 1'b0;
    exp_t         q[$];
    int           wt[N];

    one_hot_rr_arbiter #(.DATA_DEPTH(N), .INDEX_WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .grant_ready(grant_ready),
        .grant(grant),
        .grant_valid(grant_valid),
        .grant_index(grant_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        m_idx   = 0;
        m_grant = '0;
        m_valid = 1'b0;
        q.delete();
        for (int c = 0; c < N; c++) wt[c] = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic rd);
        exp_t e;
        if (m_state == 0) begin
            if (r != '0) begin
                int c;
                bit hit;
                c = 0;
                hit = 0;
                for (int k = 0; k < N; k++)
                    if (!hit && r[(m_ptr + k) % N]) begin
                        c = (m_ptr + k) % N;
                        hit = 1;
                    end
                m_grant = '0;
                m_grant[c] = 1'b1;
                m_idx = c;
                m_valid = 1'b1;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (rd) begin
                m_ptr = (m_idx + 1) % N;
                m_grant = '0;
                m_idx = 0;
                m_valid = 1'b0;
                m_state = 2;
            end
        end else begin
            m_state = 0;
        end
        e.g = m_grant;
        e.v = m_valid;
        e.i = W'(m_idx);
        q.push_back(e);
    endtask

    // Called at a falling edge; drives inputs, advances the model, compares after the rising edge
    task automatic step(input logic [N-1:0] r, input logic rd);
        exp_t         e;
        logic [N-1:0] pg;
        logic         pv;
        logic [W-1:0] pi;
        int           idx;
        req = r;
        grant_ready = rd;
        pg = grant;
        pv = grant_valid;
        pi = grant_index;
        model_step(r, rd);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("out", {20'd0, grant, grant_valid, grant_index}, {20'd0, e.g, e.v, e.i});
        check("onehot0", 32'($onehot0(grant)), 32'd1);
        idx = 0;
        for (int c = 0; c < N; c++) if (grant[c]) idx = c;
        check("index_match", 32'(grant_index), 32'(idx));
        check("valid_eq_or", 32'(grant_valid), 32'(|grant));
        if (pv && !rd) check("stable", {20'd0, grant, grant_valid, grant_index}, {20'd0, pg, pv, pi});
        for (int c = 0; c < N; c++) begin
            if (!r[c]) wt[c] = 0;
            if (grant_valid && !pv) begin
                if (grant[c]) wt[c] = 0;
                else if (r[c]) begin
                    wt[c]++;
                    check("fair", 32'(wt[c] <= N - 1), 32'd1);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_valid", 32'(grant_valid), 32'd0);
        check("rst_index", 32'(grant_index), 32'd0);
        rst = 1'b0;

        // single channel, regrant after holdoff
        step(8'h10, 1'b1);
        check("single_idx", 32'(grant_index), 32'd4);
        check("single_grant", 32'(grant), 32'h10);
        step(8'h10, 1'b1);
        check("single_acc", 32'(grant_valid), 32'd0);
        step(8'h10, 1'b1);
        check("single_hold", 32'(grant_valid), 32'd0);
        step(8'h10, 1'b1);
        check("single_regrant", 32'(grant_index), 32'd4);
        step(8'h00, 1'b1);
        step(8'h00, 1'b0);

        // all requesting: one grant every 3 cycles in index order
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 27; k++) begin
            step(8'hFF, 1'b1);
            check("rr_valid", 32'(grant_valid), 32'(k % 3 == 0));
            if (k % 3 == 0) check("rr_seq", 32'(grant_index), 32'((k / 3) % N));
        end

        // wrap search from ptr=6
        step(8'h20, 1'b1);
        check("pre_wrap", 32'(grant_index), 32'd5);
        step(8'h00, 1'b1);
        step(8'h00, 1'b0);
        step(8'h03, 1'b1);
        check("wrap0", 32'(grant_index), 32'd0);
        step(8'h03, 1'b1);
        step(8'h03, 1'b0);
        step(8'h03, 1'b1);
        check("wrap1", 32'(grant_index), 32'd1);
        step(8'h03, 1'b1);
        step(8'h00, 1'b0);

        // backpressure: grant held while req changes
        step(8'h04, 1'b0);
        check("bp_grant", 32'(grant), 32'h04);
        for (int k = 0; k < 10; k++) begin
            step(8'h80, 1'b0);
            check("bp_hold", 32'(grant), 32'h04);
        end
        step(8'h80, 1'b1);
        step(8'h80, 1'b0);
        step(8'h80, 1'b0);
        check("bp_next", 32'(grant), 32'h80);
        step(8'h00, 1'b1);
        step(8'h00, 1'b0);

        // asynchronous reset mid-grant
        step(8'hFF, 1'b0);
        check("pre_rst_valid", 32'(grant_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 32'(grant_valid), 32'd0);
        check("async_grant", 32'(grant), 32'd0);
        check("async_index", 32'(grant_index), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step(8'h00, 1'b1);
            check("post_rst_idle", 32'(grant_valid), 32'd0);
        end

        // random traffic with slowly changing requests
        begin
            logic [N-1:0] r;
            r = N'($urandom);
            for (int k = 0; k < 10000; k++) begin
                if ($urandom_range(0, 7) == 0) r = N'($urandom);
                step(r, $urandom_range(0, 2) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/one_hot_rr_arbiter.md
Name: one_hot_rr_arbiter

Overview:
- Registered round-robin arbiter that produces the one-hot select code consumed by the channel data mux in the TDC readout path.
- Takes per-channel request lines (for example, channel FIFO not-empty flags) and issues one one-hot grant at a time, with a binary index.
- Holds each grant under a valid/ready handshake until the downstream reader accepts it.
- Guarantees starvation-free service across DATA_DEPTH channels.

Parameters:
- DATA_DEPTH, 8, number of requesting channels and width of the one-hot code.
- INDEX_WIDTH, 3, width of the binary grant index. Must satisfy 2**INDEX_WIDTH >= DATA_DEPTH.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  DATA_DEPTH  per-channel request; bit i high means channel i has data.
- grant_ready  input  1  downstream accepts the current grant this cycle.
- grant  output  DATA_DEPTH  one-hot grant code, registered; all-zero when grant_valid is 0.
- grant_valid  output  1  grant and grant_index are valid.
- grant_index  output  INDEX_WIDTH  binary index of the granted channel, registered; 0 when grant_valid is 0.

Behaviour:
- Reset (asynchronous, active-high):
  - grant=0, grant_valid=0, grant_index=0.
  - Priority pointer ptr=0; state IDLE.
  - Reset asserted mid-grant drops grant_valid immediately, with no handshake.
- State IDLE:
  - At each edge, if |req, select the first channel c with req[c]=1, searching c = ptr, ptr+1, …, DATA_DEPTH-1, 0, …, ptr-1 (modulo DATA_DEPTH).
  - Register grant = 1<<c, grant_index = c, grant_valid = 1; go to GRANT.
  - Latency: req sampled high at edge n gives grant_valid high after edge n (one cycle).
  - If req=0, stay in IDLE with outputs zero.
- State GRANT:
  - grant, grant_index and grant_valid are held stable until grant_valid & grant_ready is sampled at an edge.
  - Changes in req (including the granted bit dropping) do not alter or withdraw the grant.
  - On the accept edge: ptr <= (grant_index+1) mod DATA_DEPTH; grant/grant_valid/grant_index cleared; go to HOLDOFF.
- State HOLDOFF:
  - Exactly one cycle with grant_valid=0, then unconditionally go to IDLE.
  - This lets the accepted channel's req (FIFO empty flag) update before re-arbitration.
  - Maximum accept rate is one grant per 3 cycles.
- Invariants:
  - grant is always zero or exactly one-hot.
  - grant_index always equals the position of the set bit in grant.
  - grant_valid equals |grant.
- Pointer arithmetic:
  - Wrap from DATA_DEPTH-1 to 0 explicitly. Do not rely on INDEX_WIDTH overflow when DATA_DEPTH is not a power of two.
  - Only bits 0..DATA_DEPTH-1 of the search are considered.
- Fairness:
  - A continuously requesting channel is granted within DATA_DEPTH grants.
  - With all req high, grant order is 0,1,2,…,DATA_DEPTH-1,0,…
- grant_ready while grant_valid=0 is ignored.
- No combinational path from req or grant_ready to any output.

Test Plan:
- Reset behaviour: assert rst with req=8'hFF mid-GRANT → outputs zero asynchronously. After release with req=8'h00 → grant_valid stays 0.
- Single channel: req=8'h10 at edge n, grant_ready=1 → at n+1 grant=8'h10, grant_index=4, grant_valid=1. Accept at edge n+1 → grant_valid low at n+2 (HOLDOFF) and n+3 (IDLE). Regrant at n+4 if req still high → ptr=5.
- Round-robin all requesting: req=8'hFF, grant_ready=1 constantly → grant_index sequence 0,1,…,7,0. New grant every 3 cycles.
- Wrap search: ptr=6 after granting channel 5, req=8'h03 → next grant_index=0, then ptr=1 → next grant_index=1.
- Backpressure: grant issued to channel 2, grant_ready=0 for 10 cycles while req changes to 8'h80 → grant stays 8'h04/index 2. Once grant_ready=1 → accept, ptr=3, next grant 8'h80.
- Invariant check on random req/grant_ready for 10k cycles:
  - grant is zero or one-hot, and grant_index matches it.
  - Every channel with sustained req is granted within 8 grants.
  - Outputs are stable while grant_valid & !grant_ready.
